// File: rtl/bp_me_prefetch_stream_buffer.sv
// Best-offset stream prefetch buffer between a bsg_cache DMA port and one L2 bank's memory DMA port.
// Demand reads that hit a completed prefetch are streamed locally; each demand read may launch one in-page prefetch.
module bp_me_prefetch_stream_buffer #(
    parameter int addr_width_p  = 40,
    parameter int fill_width_p  = 64,
    parameter int block_beats_p = 8,
    parameter int entries_p     = 4,
    parameter int lg_offsets_p  = 6,
    parameter int page_bits_p   = 12
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    enable_i,
    input  logic [lg_offsets_p-1:0] offset_i,
    input  logic [addr_width_p-1:0] cache_pkt_addr_i,
    input  logic                    cache_pkt_write_i,
    input  logic                    cache_pkt_v_i,
    output logic                    cache_pkt_ready_and_o,
    output logic [fill_width_p-1:0] cache_data_o,
    output logic                    cache_data_v_o,
    input  logic                    cache_data_ready_and_i,
    output logic [addr_width_p-1:0] mem_pkt_addr_o,
    output logic                    mem_pkt_write_o,
    output logic                    mem_pkt_v_o,
    input  logic                    mem_pkt_ready_and_i,
    input  logic [fill_width_p-1:0] mem_data_i,
    input  logic                    mem_data_v_i,
    output logic                    mem_data_ready_and_o,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             pf_issued_count_o
);

    localparam int blockOffW = $clog2(block_beats_p * fill_width_p / 8);
    localparam int blockW    = addr_width_p - blockOffW;
    localparam int pageLo    = page_bits_p - blockOffW;
    localparam int beatW     = $clog2(block_beats_p);
    localparam int idxW      = (entries_p > 1) ? $clog2(entries_p) : 1;

    typedef enum logic [2:0] {
        e_ready, e_wr_req, e_hit, e_miss_req, e_miss_fill, e_pf_gen, e_pf_req, e_pf_fill
    } state_e;

    state_e                state_q, state_d;
    logic [blockW-1:0]     reqBlock_q, reqBlock_d;
    logic [blockW-1:0]     pfBlock_q, pfBlock_d;
    logic [beatW-1:0]      beatCnt_q, beatCnt_d;
    logic [idxW-1:0]       hitIdx_q, hitIdx_d;
    logic [idxW-1:0]       victim_q, victim_d;
    logic [idxW-1:0]       replPtr_q, replPtr_d;
    logic [entries_p-1:0]  valid_q, valid_d;
    logic [31:0]           hitCount_q, hitCount_d;
    logic [31:0]           pfCount_q, pfCount_d;
    logic [blockW-1:0]     tag_q [entries_p];
    logic [fill_width_p-1:0] data_q [entries_p][block_beats_p];

    logic [blockW-1:0]     demandBlock, pfTarget;
    logic [entries_p-1:0]  demandMatch, targetMatch;
    logic [idxW-1:0]       demandIdx, freeIdx;
    logic                  anyFree, lastBeat, pfAllowed;
    logic [blockOffW-1:0]  unusedAddrBits;

    assign demandBlock    = cache_pkt_addr_i[addr_width_p-1:blockOffW];
    assign unusedAddrBits = cache_pkt_addr_i[blockOffW-1:0];
    assign pfTarget       = reqBlock_q + blockW'(offset_i);
    assign lastBeat       = (beatCnt_q == beatW'(block_beats_p - 1));
    assign pfAllowed      = enable_i && (offset_i != '0) && !(|targetMatch)
                            && (pfTarget[blockW-1:pageLo] == reqBlock_q[blockW-1:pageLo]);
    assign hit_count_o       = hitCount_q;
    assign pf_issued_count_o = pfCount_q;

    // Tag lookups; descending scan leaves the lowest matching / free index.
    always_comb begin
        demandMatch = '0;
        targetMatch = '0;
        demandIdx   = '0;
        freeIdx     = '0;
        anyFree     = 1'b0;
        for (int i = 0; i < entries_p; i++) begin
            demandMatch[i] = valid_q[i] && (tag_q[i] == demandBlock);
            targetMatch[i] = valid_q[i] && (tag_q[i] == pfTarget);
        end
        for (int i = entries_p - 1; i >= 0; i--) begin
            if (demandMatch[i]) demandIdx = idxW'(i);
            if (!valid_q[i]) begin
                freeIdx = idxW'(i);
                anyFree = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_ready;
            reqBlock_q <= '0;
            pfBlock_q  <= '0;
            beatCnt_q  <= '0;
            hitIdx_q   <= '0;
            victim_q   <= '0;
            replPtr_q  <= '0;
            valid_q    <= '0;
            hitCount_q <= '0;
            pfCount_q  <= '0;
        end else begin
            state_q    <= state_d;
            reqBlock_q <= reqBlock_d;
            pfBlock_q  <= pfBlock_d;
            beatCnt_q  <= beatCnt_d;
            hitIdx_q   <= hitIdx_d;
            victim_q   <= victim_d;
            replPtr_q  <= replPtr_d;
            valid_q    <= valid_d;
            hitCount_q <= hitCount_d;
            pfCount_q  <= pfCount_d;
        end
    end

    // Payload storage needs no reset: a tag is only trusted once its valid bit is set.
    always_ff @(posedge clk_i) begin
        if (state_q == e_pf_fill && mem_data_v_i) begin
            data_q[victim_q][beatCnt_q] <= mem_data_i;
            if (lastBeat) tag_q[victim_q] <= pfBlock_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        reqBlock_d = reqBlock_q;
        pfBlock_d  = pfBlock_q;
        beatCnt_d  = beatCnt_q;
        hitIdx_d   = hitIdx_q;
        victim_d   = victim_q;
        replPtr_d  = replPtr_q;
        valid_d    = valid_q;
        hitCount_d = hitCount_q;
        pfCount_d  = pfCount_q;
        case (state_q)
            e_ready: if (cache_pkt_v_i) begin
                reqBlock_d = demandBlock;
                beatCnt_d  = '0;
                if (cache_pkt_write_i) begin
                    valid_d = valid_q & ~demandMatch;
                    state_d = e_wr_req;
                end else if (|demandMatch) begin
                    hitIdx_d = demandIdx;
                    state_d  = e_hit;
                end else begin
                    state_d = e_miss_req;
                end
            end
            e_wr_req: if (mem_pkt_ready_and_i) state_d = e_ready;
            e_hit: if (cache_data_ready_and_i) begin
                beatCnt_d = beatCnt_q + beatW'(1);
                if (lastBeat) begin
                    valid_d[hitIdx_q] = 1'b0;
                    hitCount_d        = hitCount_q + 32'd1;
                    state_d           = e_pf_gen;
                end
            end
            e_miss_req: if (mem_pkt_ready_and_i) state_d = e_miss_fill;
            e_miss_fill: if (mem_data_v_i && cache_data_ready_and_i) begin
                beatCnt_d = beatCnt_q + beatW'(1);
                if (lastBeat) state_d = e_pf_gen;
            end
            e_pf_gen: begin
                pfBlock_d = pfTarget;
                beatCnt_d = '0;
                state_d   = pfAllowed ? e_pf_req : e_ready;
            end
            e_pf_req: begin
                if (mem_pkt_ready_and_i) begin
                    pfCount_d         = pfCount_q + 32'd1;
                    victim_d          = anyFree ? freeIdx : replPtr_q;
                    replPtr_d         = (replPtr_q == idxW'(entries_p - 1)) ? '0 : replPtr_q + idxW'(1);
                    valid_d[victim_d] = 1'b0;
                    state_d           = e_pf_fill;
                end else if (cache_pkt_v_i) begin
                    state_d = e_ready;
                end
            end
            e_pf_fill: if (mem_data_v_i) begin
                beatCnt_d = beatCnt_q + beatW'(1);
                if (lastBeat) begin
                    valid_d[victim_q] = 1'b1;
                    state_d           = e_ready;
                end
            end
            default: state_d = e_ready;
        endcase
    end

    // Demand ready is held low while reset is asserted even though the state register sits in e_ready.
    always_comb begin
        cache_pkt_ready_and_o = 1'b0;
        cache_data_o          = '0;
        cache_data_v_o        = 1'b0;
        mem_pkt_addr_o        = '0;
        mem_pkt_write_o       = 1'b0;
        mem_pkt_v_o           = 1'b0;
        mem_data_ready_and_o  = 1'b0;
        case (state_q)
            e_ready: cache_pkt_ready_and_o = reset_n_i;
            e_wr_req: begin
                mem_pkt_v_o     = 1'b1;
                mem_pkt_write_o = 1'b1;
                mem_pkt_addr_o  = {reqBlock_q, {blockOffW{1'b0}}};
            end
            e_hit: begin
                cache_data_v_o = 1'b1;
                cache_data_o   = data_q[hitIdx_q][beatCnt_q];
            end
            e_miss_req: begin
                mem_pkt_v_o    = 1'b1;
                mem_pkt_addr_o = {reqBlock_q, {blockOffW{1'b0}}};
            end
            e_miss_fill: begin
                cache_data_v_o       = mem_data_v_i;
                cache_data_o         = mem_data_i;
                mem_data_ready_and_o = cache_data_ready_and_i;
            end
            e_pf_req: begin
                mem_pkt_v_o    = 1'b1;
                mem_pkt_addr_o = {pfBlock_q, {blockOffW{1'b0}}};
            end
            e_pf_fill: mem_data_ready_and_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_me_prefetch_stream_buffer.sv
// Directed bench for bp_me_prefetch_stream_buffer: a table of demand transactions against a small memory
// model, plus hand-written sequences for the dropped prefetch and the mid-fill reset.
module tb_bp_me_prefetch_stream_buffer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        enable_i;
    logic [5:0]  offset_i;
    logic [39:0] cache_pkt_addr_i;
    logic        cache_pkt_write_i;
    logic        cache_pkt_v_i;
    logic        cache_pkt_ready_and_o;
    logic [63:0] cache_data_o;
    logic        cache_data_v_o;
    logic        cache_data_ready_and_i;
    logic [39:0] mem_pkt_addr_o;
    logic        mem_pkt_write_o;
    logic        mem_pkt_v_o;
    logic        mem_pkt_ready_and_i;
    logic [63:0] mem_data_i;
    logic        mem_data_v_i;
    logic        mem_data_ready_and_o;
    logic [31:0] hit_count_o;
    logic [31:0] pf_issued_count_o;

    bp_me_prefetch_stream_buffer dut (
        .clk_i                  (clk_i),
        .reset_n_i              (reset_n_i),
        .enable_i               (enable_i),
        .offset_i               (offset_i),
        .cache_pkt_addr_i       (cache_pkt_addr_i),
        .cache_pkt_write_i      (cache_pkt_write_i),
        .cache_pkt_v_i          (cache_pkt_v_i),
        .cache_pkt_ready_and_o  (cache_pkt_ready_and_o),
        .cache_data_o           (cache_data_o),
        .cache_data_v_o         (cache_data_v_o),
        .cache_data_ready_and_i (cache_data_ready_and_i),
        .mem_pkt_addr_o         (mem_pkt_addr_o),
        .mem_pkt_write_o        (mem_pkt_write_o),
        .mem_pkt_v_o            (mem_pkt_v_o),
        .mem_pkt_ready_and_i    (mem_pkt_ready_and_i),
        .mem_data_i             (mem_data_i),
        .mem_data_v_i           (mem_data_v_i),
        .mem_data_ready_and_o   (mem_data_ready_and_o),
        .hit_count_o            (hit_count_o),
        .pf_issued_count_o      (pf_issued_count_o)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [39:0] addr;
        logic        wr;
        logic [5:0]  off;
        logic        en;
        int          pfMode;     // 0 normal, 1 stall and drop the prefetch, 2 stop mid prefetch fill
        bit          expMem;
        bit          expPf;
        logic [39:0] expPfAddr;
        int          expHits;
        int          expPfs;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [39:0] addr, input logic wr, input logic [5:0] off, input logic en,
                          input int pfMode, input bit expMem, input bit expPf, input logic [39:0] expPfAddr,
                          input int expHits, input int expPfs);
        vec_t v;
        v.addr = addr; v.wr = wr; v.off = off; v.en = en; v.pfMode = pfMode;
        v.expMem = expMem; v.expPf = expPf; v.expPfAddr = expPfAddr;
        v.expHits = expHits; v.expPfs = expPfs;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] memBeat(input logic [39:0] a, input int b);
        return {a[37:6], 24'hC0FFEE, 8'(b)};
    endfunction

    // One demand transaction, then every memory/cache beat it causes, until the block is idle again.
    task automatic applyStimulus(input logic [39:0] addr, input logic wr, input logic [5:0] off,
                                 input logic en, input int pfMode,
                                 output bit memSeen, output logic [39:0] memAddr, output logic memWrite,
                                 output bit pfSeen, output logic [39:0] pfAddr, output int beats,
                                 output int dataErr, output int firstValid, output bit timedOut);
        bit accepted, demandDone, wasDone, memActive, pfActive, finished;
        logic [39:0] memBlkAddr;
        int memIdx, pfBeats;
        memSeen = 0; memAddr = '0; memWrite = 0; pfSeen = 0; pfAddr = '0;
        beats = 0; dataErr = 0; firstValid = -1; timedOut = 0;
        accepted = 0; demandDone = 0; memActive = 0; pfActive = 0; finished = 0;
        memBlkAddr = '0; memIdx = 0; pfBeats = 0;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk_i);
            cache_pkt_addr_i = addr; cache_pkt_write_i = wr; cache_pkt_v_i = 1'b1;
            offset_i = off; enable_i = en;
            mem_data_v_i = 1'b0; mem_pkt_ready_and_i = 1'b1; cache_data_ready_and_i = 1'b1;
            #1;
            if (cache_pkt_ready_and_o) accepted = 1;
        end
        if (!accepted) begin
            timedOut = 1;
            cache_pkt_v_i = 1'b0;
        end else begin
            for (int c = 0; c < 300 && !finished; c++) begin
                @(negedge clk_i);
                cache_pkt_v_i          = 1'b0;
                cache_data_ready_and_i = ((c % 4) != 2);
                mem_pkt_ready_and_i    = !(pfMode == 1 && demandDone);
                mem_data_v_i           = memActive;
                mem_data_i             = memBeat(memBlkAddr, memIdx);
                #1;
                wasDone = demandDone;
                if (mem_data_v_i && mem_data_ready_and_o) begin
                    memIdx++;
                    if (memIdx == 8) memActive = 0;
                    if (pfActive) pfBeats++;
                end
                if (cache_data_v_o && firstValid < 0) firstValid = c;
                if (cache_data_v_o && cache_data_ready_and_i) begin
                    if (cache_data_o !== memBeat({addr[39:6], 6'b0}, beats)) dataErr++;
                    beats++;
                    if (beats == 8) demandDone = 1;
                end
                if (mem_pkt_v_o) begin
                    if (!wasDone && !memSeen) begin
                        memSeen = 1; memAddr = mem_pkt_addr_o; memWrite = mem_pkt_write_o;
                    end else if (wasDone) begin
                        pfSeen = 1; pfAddr = mem_pkt_addr_o;
                    end
                    if (mem_pkt_ready_and_i) begin
                        if (!mem_pkt_write_o) begin
                            memActive = 1; memIdx = 0; memBlkAddr = mem_pkt_addr_o;
                        end
                        if (wasDone) pfActive = 1;
                        else if (wr) demandDone = 1;
                    end else if (pfMode == 1 && wasDone) begin
                        finished = 1;
                    end
                end
                if (pfMode == 2 && pfActive && pfBeats == 3) finished = 1;
                if (demandDone && !memActive && cache_pkt_ready_and_o) finished = 1;
            end
            if (!finished) timedOut = 1;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          memSeen, pfSeen, timedOut;
        logic [39:0] memAddr, pfAddr;
        logic        memWrite;
        int          beats, dataErr, firstValid;
        string       tag;

        reset_n_i = 1'b0; enable_i = 1'b0; offset_i = '0; cache_pkt_addr_i = '0;
        cache_pkt_write_i = 1'b0; cache_pkt_v_i = 1'b0; cache_data_ready_and_i = 1'b0;
        mem_pkt_ready_and_i = 1'b0; mem_data_i = '0; mem_data_v_i = 1'b0;

        //     addr          wr    off    en  mode mem pf  pfAddr        hits pfs
        addVec(40'h1000,     1'b0, 6'd2, 1'b1, 0, 1, 1, 40'h1080,      0, 1);
        addVec(40'h1080,     1'b0, 6'd2, 1'b1, 0, 0, 1, 40'h1100,      1, 2);
        addVec(40'h1FC0,     1'b0, 6'd4, 1'b1, 0, 1, 0, 40'h0,         1, 2);
        addVec(40'h1100,     1'b0, 6'd0, 1'b1, 0, 0, 0, 40'h0,         2, 2);
        addVec(40'h1000,     1'b0, 6'd2, 1'b1, 0, 1, 1, 40'h1080,      2, 3);
        addVec(40'h1080,     1'b1, 6'd2, 1'b1, 0, 1, 0, 40'h0,         2, 3);
        addVec(40'h1080,     1'b0, 6'd0, 1'b1, 0, 1, 0, 40'h0,         2, 3);
        addVec(40'h2000,     1'b0, 6'd1, 1'b0, 0, 1, 0, 40'h0,         2, 3);
        addVec(40'h3000,     1'b0, 6'd1, 1'b1, 0, 1, 1, 40'h3040,      2, 4);
        addVec(40'h3000,     1'b0, 6'd1, 1'b1, 0, 1, 0, 40'h0,         2, 4);
        addVec(40'h4000,     1'b0, 6'd1, 1'b1, 1, 1, 1, 40'h4040,      2, 4);
        addVec(40'h4040,     1'b0, 6'd1, 1'b1, 0, 1, 1, 40'h4080,      2, 5);
        addVec(40'h5000,     1'b0, 6'd1, 1'b1, 2, 1, 1, 40'h5040,      2, 6);
        addVec(40'h3040,     1'b0, 6'd0, 1'b1, 0, 1, 0, 40'h0,         0, 0);
        addVec(40'h6000,     1'b0, 6'd1, 1'b1, 0, 1, 1, 40'h6040,      0, 1);
        addVec(40'h7000,     1'b0, 6'd1, 1'b1, 0, 1, 1, 40'h7040,      0, 2);
        addVec(40'h8000,     1'b0, 6'd1, 1'b1, 0, 1, 1, 40'h8040,      0, 3);
        addVec(40'h9000,     1'b0, 6'd1, 1'b1, 0, 1, 1, 40'h9040,      0, 4);
        addVec(40'hA000,     1'b0, 6'd1, 1'b1, 0, 1, 1, 40'hA040,      0, 5);
        addVec(40'h7040,     1'b0, 6'd0, 1'b1, 0, 0, 0, 40'h0,         1, 5);
        addVec(40'h6040,     1'b0, 6'd0, 1'b1, 0, 1, 0, 40'h0,         1, 5);
        addVec(40'hA040,     1'b0, 6'd0, 1'b1, 0, 0, 0, 40'h0,         2, 5);

        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("reset pktReady",  cache_pkt_ready_and_o, 0);
        checkOutput("reset memValid",  mem_pkt_v_o, 0);
        checkOutput("reset memAddr",   mem_pkt_addr_o, 0);
        checkOutput("reset dataValid", cache_data_v_o, 0);
        checkOutput("reset dataOut",   cache_data_o, 0);
        checkOutput("reset memReady",  mem_data_ready_and_o, 0);
        checkOutput("reset hits",      hit_count_o, 0);
        checkOutput("reset pfs",       pf_issued_count_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        #1;
        checkOutput("idle pktReady", cache_pkt_ready_and_o, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wr, vecs[i].off, vecs[i].en, vecs[i].pfMode,
                          memSeen, memAddr, memWrite, pfSeen, pfAddr, beats, dataErr, firstValid, timedOut);
            tag = $sformatf("v%0d", i);
            checkOutput({tag, " timeout"}, timedOut, 0);
            checkOutput({tag, " memDemand"}, memSeen, vecs[i].expMem);
            if (vecs[i].expMem) begin
                checkOutput({tag, " memAddr"}, memAddr, {vecs[i].addr[39:6], 6'b0});
                checkOutput({tag, " memWrite"}, memWrite, vecs[i].wr);
            end
            if (!vecs[i].wr) begin
                checkOutput({tag, " beats"}, beats, 8);
                checkOutput({tag, " dataErrors"}, dataErr, 0);
                if (!vecs[i].expMem) checkOutput({tag, " firstBeatCycle"}, firstValid, 0);
            end
            checkOutput({tag, " pfIssued"}, pfSeen, vecs[i].expPf);
            if (vecs[i].expPf) checkOutput({tag, " pfAddr"}, pfAddr, vecs[i].expPfAddr);
            checkOutput({tag, " hitCount"}, hit_count_o, vecs[i].expHits);
            checkOutput({tag, " pfCount"}, pf_issued_count_o, vecs[i].expPfs);

            if (vecs[i].pfMode == 1) begin
                // demand arrives while the prefetch is still waiting on memory
                cache_pkt_addr_i = vecs[i+1].addr; cache_pkt_write_i = 1'b0; cache_pkt_v_i = 1'b1;
                #1;
                checkOutput("drop memValidBefore", mem_pkt_v_o, 1);
                @(negedge clk_i);
                #1;
                checkOutput("drop memValidAfter", mem_pkt_v_o, 0);
                checkOutput("drop demandReady", cache_pkt_ready_and_o, 1);
                checkOutput("drop pfCount", pf_issued_count_o, vecs[i].expPfs);
                cache_pkt_v_i = 1'b0;
            end else if (vecs[i].pfMode == 2) begin
                @(negedge clk_i);
                reset_n_i = 1'b0;
                mem_data_v_i = 1'b0;
                #1;
                checkOutput("midfill reset hits", hit_count_o, 0);
                checkOutput("midfill reset pfs", pf_issued_count_o, 0);
                checkOutput("midfill reset pktReady", cache_pkt_ready_and_o, 0);
                checkOutput("midfill reset memReady", mem_data_ready_and_o, 0);
                @(negedge clk_i);
                reset_n_i = 1'b1;
                #1;
                checkOutput("midfill release pktReady", cache_pkt_ready_and_o, 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bp_me_prefetch_stream_buffer.md
Name: bp_me_prefetch_stream_buffer

Overview:
- Per-bank best-offset prefetch buffer, parametrised in entry count, block size, fill width and offset range.
- Sits between one bsg_cache DMA interface and the memory-side DMA interface of an L2 bank.
- Demand read misses that hit a prefetched block are served from local storage; all other demand reads are forwarded to memory.
- After each demand read, one prefetch is issued at demand_block + offset, staying within the demand page.

Parameters:
- addr_width_p, 40: DMA address width (bytes).
- fill_width_p, 64: DMA data beat width.
- block_beats_p, 8: beats per cache block (power of 2, ≥2).
- entries_p, 4: prefetch buffer entries (power of 2, ≥1).
- lg_offsets_p, 6: width of the prefetch offset, in blocks.
- page_bits_p, 12: log2 of the page size; a prefetch never crosses a page.

Ports:
- clk_i, in, 1: clock.
- reset_n_i, in, 1: asynchronous active-low reset.
- enable_i, in, 1: prefetch enable. Sampled when a prefetch would be generated.
- offset_i, in, lg_offsets_p: prefetch distance in blocks. 0 means no prefetch.
- cache_pkt_addr_i, in, addr_width_p: demand address from bsg_cache. Low block-offset bits are ignored.
- cache_pkt_write_i, in, 1: 1 = writeback request, 0 = fill request.
- cache_pkt_v_i, in, 1: demand request valid.
- cache_pkt_ready_and_o, out, 1: demand request accepted when high with valid.
- cache_data_o, out, fill_width_p: fill beat to the cache.
- cache_data_v_o, out, 1: fill beat valid.
- cache_data_ready_and_i, in, 1: cache accepts the fill beat.
- mem_pkt_addr_o, out, addr_width_p: block-aligned address to memory.
- mem_pkt_write_o, out, 1: request is a writeback.
- mem_pkt_v_o, out, 1: memory request valid.
- mem_pkt_ready_and_i, in, 1: memory accepts the request.
- mem_data_i, in, fill_width_p: fill beat from memory.
- mem_data_v_i, in, 1: fill beat valid.
- mem_data_ready_and_o, out, 1: block accepts the fill beat.
- hit_count_o, out, 32: demand reads served from the buffer. Wraps at 2^32.
- pf_issued_count_o, out, 32: prefetch requests accepted by memory. Wraps at 2^32.

Behaviour:
- Block address = addr[addr_width_p-1:lg(block_beats_p*fill_width_p/8)].
- Each entry holds: valid, block tag, and block_beats_p beats. An entry becomes valid only after its final fill beat; partial entries never hit.
- Reset is asynchronous:
  - all entries invalid; replacement pointer = 0; state = e_ready;
  - counters = 0; all valid/ready outputs = 0; data/addr outputs = 0.
- Reset mid-transfer abandons the transfer. In-flight memory beats are memory's responsibility.
- Handshakes are ready/valid. A transfer occurs only when both are high in the same cycle. No combinational path from cache_data_ready_and_i to cache_pkt_ready_and_o.

FSM:
- e_ready:
  - cache_pkt_ready_and_o = 1. On accept, register the request.
  - Write: invalidate any matching entry in the same cycle, go to e_wr_req.
  - Read, tag matches a valid entry: go to e_hit.
  - Read, no match: go to e_miss_req.
- e_wr_req: mem_pkt_v_o = 1 with write = 1. On accept, go to e_ready. No prefetch follows a write.
- e_hit:
  - Stream beats 0..block_beats_p-1 from the entry to the cache_data port, one per handshake.
  - First beat is valid the cycle after accept (latency 1).
  - On the final beat, invalidate the entry, increment hit_count_o, go to e_pf_gen.
- e_miss_req: forward the read packet to memory. On accept, go to e_miss_fill.
- e_miss_fill:
  - Pass-through: mem_data_ready_and_o = cache_data_ready_and_i; cache_data_v_o = mem_data_v_i.
  - Count beats; after the last beat, go to e_pf_gen.
- e_pf_gen (1 cycle):
  - target = demand_block + offset_i.
  - Go to e_pf_req only if all hold: enable_i = 1; offset_i ≠ 0; target page bits equal demand page bits; target matches no valid entry.
  - Otherwise go to e_ready.
  - Block-address addition is unsigned, truncated to block address width; wraparound is caught by the page check.
- e_pf_req:
  - mem_pkt_v_o = 1, read, target address.
  - If cache_pkt_v_i is high while memory has not yet accepted, drop the prefetch (demand priority), deassert mem_pkt_v_o, go to e_ready.
  - On accept, increment pf_issued_count_o, pick the victim entry, go to e_pf_fill.
  - Victim = lowest-index invalid entry; if none, the replacement pointer. The pointer then increments mod entries_p.
- e_pf_fill:
  - mem_data_ready_and_o = 1. Write beats into the victim; the victim is invalid during the fill.
  - On the last beat, set valid with the target tag, go to e_ready.
  - cache_pkt_ready_and_o = 0 for the whole fill.
- cache_data_v_o = 0 and mem_data_ready_and_o = 0 in every state not listed above as driving them.

Test Plan:
- Read at 0x1000, offset_i = 2, enable_i = 1 → miss forwarded; 8 beats passed through; prefetch at 0x1080; pf_issued_count_o = 1.
- Then read 0x1080 → no mem_pkt_v_o; 8 beats from the buffer, first beat 1 cycle after accept; hit_count_o = 1; next prefetch at 0x1100.
- Read 0x1FC0, offset_i = 4 → target lies in the next page; no prefetch; state returns to e_ready.
- Writeback to 0x1080 while that block is valid → entry invalidated; later read 0x1080 misses to memory.
- cache_pkt_v_i asserted during e_pf_req with mem_pkt_ready_and_i = 0 → prefetch dropped; pf_issued_count_o unchanged; demand accepted next cycle.
- entries_p = 4: five distinct prefetches → fifth fill overwrites entry 0; reset_n_i pulsed mid-fill → all entries invalid, counters 0.
